// File: rtl/ppu_fetch_scheduler.sv
// Background tile fetch scheduler sharing one VRAM port between the PPU fetch slots and a CPU port.
// Optional macro PPU_SCHED_STALL_CNT_EN adds the 16-bit stall_cnt output.
module ppu_fetch_scheduler #(
  parameter logic [13:0] PT_BASE  = 14'h1000,
  parameter logic [13:0] NT_BASE  = 14'h2000,
  parameter int          H_ACTIVE = 512,
  parameter int          V_ACTIVE = 240
) (
  input  logic        CLOCK_24,
  input  logic        RESET_N,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  input  logic        render_en,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [13:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_rvalid,
  output logic [7:0]  cpu_rdata,
  output logic [13:0] vram_addr,
  output logic        vram_we,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata,
  output logic        tile_valid,
  output logic [7:0]  tile_nt,
  output logic [7:0]  tile_lo,
  output logic [7:0]  tile_hi
`ifdef PPU_SCHED_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_NT, S_PT_LO, S_PT_HI, S_CPU} state_t;

  localparam logic [9:0] LP_H_ACTIVE = 10'(H_ACTIVE);
  localparam logic [9:0] LP_V_ACTIVE = 10'(V_ACTIVE);

  state_t      r_state;
  logic [7:0]  r_nt;
  logic [7:0]  r_lo;
  logic        r_tile_valid;
  logic [7:0]  r_tile_nt;
  logic [7:0]  r_tile_lo;
  logic [7:0]  r_tile_hi;
  logic        r_rvalid;

  logic        w_win;
  logic [2:0]  w_slot;
  logic [13:0] w_nt_addr;
  logic [13:0] w_pt_lo_addr;
  logic [13:0] w_pt_hi_addr;
  logic        w_fetch_nt;
  logic        w_fetch_lo;
  logic        w_fetch_hi;
  logic        w_fetch;
  logic        w_grant;
  logic [13:0] w_vram_addr;
  logic        w_vram_we;
  logic [7:0]  w_vram_wdata;

  assign w_win  = render_en && (vpos < LP_V_ACTIVE) && (hpos < LP_H_ACTIVE);
  assign w_slot = hpos[2:0];

  // 12-bit table indices zero-extended; the base add wraps modulo 2^14
  assign w_nt_addr    = NT_BASE + {2'b00, vpos[8], hpos[8], vpos[7:3], hpos[7:3]};
  assign w_pt_lo_addr = PT_BASE + {2'b00, r_nt, 1'b0, vpos[2:0]};
  assign w_pt_hi_addr = PT_BASE + {2'b00, r_nt, 1'b1, vpos[2:0]};

  // PT reads only follow an NT read issued at slot 0 of the same tile
  assign w_fetch_nt = RESET_N && w_win && (w_slot == 3'd0);
  assign w_fetch_lo = RESET_N && w_win && (w_slot == 3'd2) && (r_state == S_NT);
  assign w_fetch_hi = RESET_N && w_win && (w_slot == 3'd4) && (r_state == S_PT_LO);
  assign w_fetch    = w_fetch_nt || w_fetch_lo || w_fetch_hi;

  // In the window only slot 6 is a CPU slot; outside it the FSM must have settled to IDLE
  assign w_grant = RESET_N && cpu_req && !w_fetch &&
                   (w_win ? (w_slot == 3'd6) : (r_state == S_IDLE));

  always_comb begin
    w_vram_addr  = 14'h0000;
    w_vram_we    = 1'b0;
    w_vram_wdata = 8'h00;
    if (w_fetch_nt) begin
      w_vram_addr = w_nt_addr;
    end else if (w_fetch_lo) begin
      w_vram_addr = w_pt_lo_addr;
    end else if (w_fetch_hi) begin
      w_vram_addr = w_pt_hi_addr;
    end else if (w_grant) begin
      w_vram_addr  = cpu_addr;
      w_vram_we    = cpu_we;
      w_vram_wdata = cpu_wdata;
    end
  end

  always_ff @(posedge CLOCK_24) begin
    if (!RESET_N) begin
      r_state      <= S_IDLE;
      r_tile_valid <= 1'b0;
      r_tile_nt    <= 8'h00;
      r_tile_lo    <= 8'h00;
      r_tile_hi    <= 8'h00;
      r_rvalid     <= 1'b0;
    end else begin
      r_tile_valid <= 1'b0;
      r_rvalid     <= w_grant && !cpu_we;
      if (!w_win) begin
        r_state <= S_IDLE;
      end else begin
        case (w_slot)
          3'd0: r_state <= S_NT;
          3'd2: if (r_state == S_NT)    r_state <= S_PT_LO;
          3'd4: if (r_state == S_PT_LO) r_state <= S_PT_HI;
          3'd5: if (r_state == S_PT_HI) begin
            r_tile_nt    <= r_nt;
            r_tile_lo    <= r_lo;
            r_tile_hi    <= vram_rdata;
            r_tile_valid <= 1'b1;
          end
          3'd6: if (r_state == S_PT_HI) r_state <= S_CPU;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK_24) begin
    if (w_win && (w_slot == 3'd1) && (r_state == S_NT))    r_nt <= vram_rdata;
    if (w_win && (w_slot == 3'd3) && (r_state == S_PT_LO)) r_lo <= vram_rdata;
  end

`ifdef PPU_SCHED_STALL_CNT_EN
  logic [15:0] r_stall;

  always_ff @(posedge CLOCK_24) begin
    if (!RESET_N) begin
      r_stall <= 16'h0000;
    end else if (cpu_req && !w_grant && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'h0001;
    end
  end

  assign stall_cnt = RESET_N ? r_stall : 16'h0000;
`endif

  // Outputs read zero throughout reset, so a read return in flight is never seen
  assign cpu_ready  = w_grant;
  assign cpu_rvalid = RESET_N && r_rvalid;
  assign cpu_rdata  = (RESET_N && r_rvalid) ? vram_rdata : 8'h00;
  assign vram_addr  = w_vram_addr;
  assign vram_we    = w_vram_we;
  assign vram_wdata = w_vram_wdata;
  assign tile_valid = RESET_N && r_tile_valid;
  assign tile_nt    = RESET_N ? r_tile_nt : 8'h00;
  assign tile_lo    = RESET_N ? r_tile_lo : 8'h00;
  assign tile_hi    = RESET_N ? r_tile_hi : 8'h00;

endmodule

// File: tb/tb_ppu_fetch_scheduler.sv
// Directed bench for ppu_fetch_scheduler with a slot-rule reference model and a behavioural VRAM.
module tb_ppu_fetch_scheduler;

  localparam int PT_B = 'h1000;
  localparam int NT_B = 'h2000;

  logic        CLOCK_24 = 1'b0;
  logic        RESET_N;
  logic [9:0]  hpos;
  logic [9:0]  vpos;
  logic        render_en;
  logic        cpu_req;
  logic        cpu_we;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ready;
  logic        cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic [13:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata = 8'h00;
  logic        tile_valid;
  logic [7:0]  tile_nt;
  logic [7:0]  tile_lo;
  logic [7:0]  tile_hi;
`ifdef PPU_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  always #5 CLOCK_24 = ~CLOCK_24;

  ppu_fetch_scheduler dut (
    .CLOCK_24  (CLOCK_24),
    .RESET_N   (RESET_N),
    .hpos      (hpos),
    .vpos      (vpos),
    .render_en (render_en),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ready (cpu_ready),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata (cpu_rdata),
    .vram_addr (vram_addr),
    .vram_we   (vram_we),
    .vram_wdata(vram_wdata),
    .vram_rdata(vram_rdata),
    .tile_valid(tile_valid),
    .tile_nt   (tile_nt),
    .tile_lo   (tile_lo),
    .tile_hi   (tile_hi)
`ifdef PPU_SCHED_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  logic [7:0] mem [0:16383];

  always @(posedge CLOCK_24) begin
    if (vram_we) mem[vram_addr] <= vram_wdata;
    vram_rdata <= mem[vram_addr];
  end

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: whether a tile begun at slot 0 is still alive, plus registered expectations
  bit          m_inprog = 0;
  bit          m_tv = 0;
  logic [7:0]  m_tnt = 0, m_tlo = 0, m_thi = 0;
  bit          m_rv = 0;
  logic [7:0]  m_rd = 0;
  int          m_stall = 0;
  bit          m_g;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (hpos=%0d vpos=%0d)", nm, act, exp, hpos, vpos);
  endtask

  function automatic bit in_win();
    return render_en && (int'(vpos) < 240) && (int'(hpos) < 512);
  endfunction

  function automatic logic [13:0] nt_addr();
    int a;
    a = NT_B + ((int'(vpos) >> 8) & 1) * 2048 + ((int'(hpos) >> 8) & 1) * 1024 +
        ((int'(vpos) >> 3) & 31) * 32 + ((int'(hpos) >> 3) & 31);
    return 14'(a % 16384);
  endfunction

  function automatic logic [13:0] pt_addr(input logic [7:0] nt, input int plane);
    int a;
    a = PT_B + int'(nt) * 16 + plane * 8 + (int'(vpos) % 8);
    return 14'(a % 16384);
  endfunction

  task automatic compare();
    bit         w, f;
    int         s;
    logic [13:0] ea;
    logic [13:0] e_addr;
    w  = in_win();
    s  = int'(hpos) % 8;
    f  = 0;
    ea = '0;
    if (RESET_N && w) begin
      if (s == 0) begin
        f = 1; ea = nt_addr();
      end else if (m_inprog && (s == 2 || s == 4)) begin
        f = 1; ea = pt_addr(mem[nt_addr()], (s == 4) ? 1 : 0);
      end
    end
    m_g = RESET_N && cpu_req && !f && (w ? (s == 6) : !m_inprog);
    e_addr = f ? ea : (m_g ? cpu_addr : 14'h0);
    chk("vram_addr",  32'(vram_addr),  32'(e_addr));
    chk("vram_we",    32'(vram_we),    32'(m_g && cpu_we));
    chk("vram_wdata", 32'(vram_wdata), 32'((!f && m_g) ? cpu_wdata : 8'h00));
    chk("cpu_ready",  32'(cpu_ready),  32'(m_g));
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(RESET_N && m_rv));
    chk("cpu_rdata",  32'(cpu_rdata),  32'((RESET_N && m_rv) ? m_rd : 8'h00));
    chk("tile_valid", 32'(tile_valid), 32'(RESET_N && m_tv));
    chk("tile_nt",    32'(tile_nt),    32'(RESET_N ? m_tnt : 8'h00));
    chk("tile_lo",    32'(tile_lo),    32'(RESET_N ? m_tlo : 8'h00));
    chk("tile_hi",    32'(tile_hi),    32'(RESET_N ? m_thi : 8'h00));
`ifdef PPU_SCHED_STALL_CNT_EN
    chk("stall_cnt",  32'(stall_cnt),  RESET_N ? 32'(m_stall) : 32'd0);
`endif
  endtask

  task automatic model_update();
    bit w;
    int s;
    w = in_win();
    s = int'(hpos) % 8;
    if (!RESET_N) begin
      m_inprog = 0; m_tv = 0; m_tnt = 0; m_tlo = 0; m_thi = 0;
      m_rv = 0; m_rd = 0; m_stall = 0;
    end else begin
      if (cpu_req && !m_g && m_stall < 65535) m_stall++;
      m_rv = m_g && !cpu_we;
      m_rd = mem[cpu_addr];
      m_tv = w && (s == 5) && m_inprog;
      if (m_tv) begin
        m_tnt = mem[nt_addr()];
        m_tlo = mem[pt_addr(m_tnt, 0)];
        m_thi = mem[pt_addr(m_tnt, 1)];
      end
      m_inprog = w ? ((s == 0) ? 1'b1 : m_inprog) : 1'b0;
    end
  endtask

  task automatic settle();
    @(negedge CLOCK_24);
    compare();
  endtask

  task automatic advance();
    @(posedge CLOCK_24);
    model_update();
    #1;
  endtask

  task automatic cyc();
    settle();
    advance();
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    RESET_N = 0; hpos = 10'd0; vpos = 10'd0; render_en = 1; cpu_req = 1;
    cpu_we = 0; cpu_addr = 14'h2005; cpu_wdata = 8'h00;

    // Reset with an active window and a pending request
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("rst_vram_addr", 32'(vram_addr), 32'h0);
      chk("rst_cpu_ready", 32'(cpu_ready), 32'h0);
      chk("rst_tile_valid", 32'(tile_valid), 32'h0);
      advance();
    end

    // One tile at vpos=9, hpos=16..23
    RESET_N = 1; cpu_req = 0; vpos = 10'd9;
    mem[14'h2022] = 8'h3A; mem[14'h13A1] = 8'h5C; mem[14'h13A9] = 8'hC5;
    for (int h = 16; h <= 23; h++) begin
      hpos = 10'(h);
      settle();
      if (h == 16) chk("nt_addr", 32'(vram_addr), 32'h2022);
      if (h == 18) chk("ptlo_addr", 32'(vram_addr), 32'h13A1);
      if (h == 20) chk("pthi_addr", 32'(vram_addr), 32'h13A9);
      if (h == 21) chk("tile_valid_early", 32'(tile_valid), 32'h0);
      if (h == 22) begin
        chk("tile_valid_22", 32'(tile_valid), 32'h1);
        chk("tile_nt_22", 32'(tile_nt), 32'h3A);
        chk("tile_lo_22", 32'(tile_lo), 32'h5C);
        chk("tile_hi_22", 32'(tile_hi), 32'hC5);
      end
      advance();
    end

    // Blank line write is granted immediately once the FSM is idle
    vpos = 10'd300; hpos = 10'd100;
    cyc();
    cpu_req = 1; cpu_we = 1; cpu_addr = 14'h2005; cpu_wdata = 8'h55;
    settle();
    chk("blank_ready", 32'(cpu_ready), 32'h1);
    chk("blank_we", 32'(vram_we), 32'h1);
    chk("blank_addr", 32'(vram_addr), 32'h2005);
    chk("blank_wdata", 32'(vram_wdata), 32'h55);
    advance();
    cpu_req = 0; cpu_we = 0;

    // Read requested at hpos=1 waits for the slot-6 CPU slot
    vpos = 10'd20; hpos = 10'd0;
    cyc();
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h2005;
    for (int h = 1; h <= 7; h++) begin
      hpos = 10'(h);
      settle();
      if (h < 6) chk("rd_wait_ready", 32'(cpu_ready), 32'h0);
      if (h == 6) chk("rd_grant_ready", 32'(cpu_ready), 32'h1);
      if (h == 7) begin
        chk("rd_rvalid", 32'(cpu_rvalid), 32'h1);
        chk("rd_rdata", 32'(cpu_rdata), 32'h55);
      end
      advance();
      if (h == 6) cpu_req = 0;
    end

    // render_en dropped at slot 3 with a write pending
    vpos = 10'd30; cpu_we = 1; cpu_addr = 14'h0100; cpu_wdata = 8'h77;
    for (int h = 32; h <= 38; h++) begin
      hpos = 10'(h);
      render_en = (h < 35);
      if (h == 33) cpu_req = 1;
      settle();
      if (h >= 33 && h <= 35) chk("drop_wait_ready", 32'(cpu_ready), 32'h0);
      if (h == 36) chk("drop_grant_ready", 32'(cpu_ready), 32'h1);
      if (h >= 36) chk("drop_no_tile", 32'(tile_valid), 32'h0);
      advance();
      if (h == 36) begin cpu_req = 0; cpu_we = 0; end
    end

    // Reset lands on the cycle after a granted read
    render_en = 0; vpos = 10'd300; hpos = 10'd200;
    cyc();
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0100;
    settle();
    chk("prerst_ready", 32'(cpu_ready), 32'h1);
    advance();
    RESET_N = 0;
    settle();
    chk("midrst_rvalid", 32'(cpu_rvalid), 32'h0);
    chk("midrst_rdata", 32'(cpu_rdata), 32'h0);
    chk("midrst_ready", 32'(cpu_ready), 32'h0);
    chk("midrst_addr", 32'(vram_addr), 32'h0);
`ifdef PPU_SCHED_STALL_CNT_EN
    chk("midrst_stall", 32'(stall_cnt), 32'h0);
`endif
    advance();
    RESET_N = 1; cpu_req = 0;
    settle();
    chk("postrst_rvalid", 32'(cpu_rvalid), 32'h0);
    advance();
    cpu_req = 1;
    settle();
    chk("reissue_ready", 32'(cpu_ready), 32'h1);
    advance();
    cpu_req = 0;
    settle();
    chk("reissue_rvalid", 32'(cpu_rvalid), 32'h1);
    chk("reissue_rdata", 32'(cpu_rdata), 32'h77);
    advance();

`ifdef PPU_SCHED_STALL_CNT_EN
    // Request starved by fetch slots 0..5 long enough to saturate
    RESET_N = 0;
    cyc();
    RESET_N = 1; render_en = 1; vpos = 10'd50; cpu_req = 1; cpu_we = 0;
    for (int i = 0; i < 70000; i++) begin
      hpos = 10'(i % 6);
      cyc();
    end
    hpos = 10'd1;
    settle();
    chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
    chk("stall_ready", 32'(cpu_ready), 32'h0);
    advance();
    cpu_req = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
